rom_day4_scanner: RTL and testbench

- Sequencer and accumulator directly downstream of the Day 4 flag ROM.
- Each 32-bit ROM word packs one flag bit per grid cell: 1 means the cell is "@" with fewer than 4 neighbours.
- On start, the block sweeps ROM addresses 0..DEPTH-1, popcounts each returned word and accumulates the Day 4 answer.
- Presents the answer with a sticky done flag to the top-level/UART reporter.

---
 rtl/rom_day4_scanner.sv | 125 ++++++++++++
 tb/tb_rom_day4_scanner.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/rom_day4_scanner.sv
// Sweeps the Day 4 flag ROM once per start and accumulates the popcount of every word.
// Optional macro ROM_SCAN_POPCNT_PIPE_EN registers the popcount (extra valid stage v2).
module rom_day4_scanner #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 12224,
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned SUM_W  = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [WIDTH-1:0]  rom_data,
    output logic              busy,
    output logic              done,
    output logic [SUM_W-1:0]  total
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t             state;
    state_t             state_next;
    logic               v1;
    logic               issue_c;
    logic               start_ok_c;
    logic               drain_clear_c;
    logic               acc_en_c;
    logic [SUM_W-1:0]   acc_val_c;
    logic [SUM_W-1:0]   pop_c;

    // Full-width population count, zero-extended to the accumulator width.
    function automatic logic [SUM_W-1:0] popcount(input logic [WIDTH-1:0] d);
        logic [SUM_W-1:0] c;
        c = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            c = c + SUM_W'(d[i]);
        end
        return c;
    endfunction

    assign pop_c = popcount(rom_data);

`ifdef ROM_SCAN_POPCNT_PIPE_EN
    logic             v2;
    logic [SUM_W-1:0] pop_q;

    // Registered popcount stage; v2 follows v1 by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2    <= 1'b0;
            pop_q <= '0;
        end else begin
            v2    <= v1;
            pop_q <= pop_c;
        end
    end

    assign acc_en_c      = v2;
    assign acc_val_c     = pop_q;
    // In DRAIN nothing new is issued, so only v1 can still refill v2.
    assign drain_clear_c = ~v1;
`else
    assign acc_en_c      = v1;
    assign acc_val_c     = pop_c;
    // v1 is the only stage and always retires on this edge in DRAIN.
    assign drain_clear_c = 1'b1;
`endif

    // Next-state and per-cycle control.
    always_comb begin
        state_next = state;
        issue_c    = 1'b0;
        start_ok_c = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    start_ok_c = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                issue_c = 1'b1;
                if (rom_addr == LAST_ADDR) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_clear_c) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, address, flags and accumulator registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rom_addr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            total    <= '0;
            v1       <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == RUN) || (state_next == DRAIN);
            done  <= (state_next == DONE);
            v1    <= issue_c;
            if (start_ok_c) begin
                rom_addr <= '0;
            end else if (issue_c && (rom_addr != LAST_ADDR)) begin
                rom_addr <= rom_addr + ADDR_W'(1);
            end
            if (start_ok_c) begin
                total <= '0;
            end else if (acc_en_c) begin
                total <= total + acc_val_c;
            end
        end
    end

endmodule

// File: tb/tb_rom_day4_scanner.sv
// Directed bench: a DEPTH=4 scanner driven from a per-cycle vector table, plus a full-depth sweep.
module tb_rom_day4_scanner;

`ifdef ROM_SCAN_POPCNT_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        start_big;
    logic [13:0] addr_s;
    logic [13:0] addr_b;
    logic [31:0] data_s;
    logic [31:0] data_b;
    logic        busy_s, done_s, busy_b, done_b;
    logic [19:0] total_s, total_b;
    logic [31:0] mem [4];
    int          oob_s;
    int          max_addr_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rom_day4_scanner #(.WIDTH(32), .DEPTH(4), .ADDR_W(14), .SUM_W(20)) dut (
        .clk(clk), .rst(rst), .start(start), .rom_addr(addr_s), .rom_data(data_s),
        .busy(busy_s), .done(done_s), .total(total_s)
    );

    rom_day4_scanner dut_big (
        .clk(clk), .rst(rst), .start(start_big), .rom_addr(addr_b), .rom_data(data_b),
        .busy(busy_b), .done(done_b), .total(total_b)
    );

    // Registered-read ROM models with one cycle of latency.
    always @(posedge clk) begin
        data_s <= (addr_s < 14'd4) ? mem[addr_s[1:0]] : 32'h0;
        data_b <= 32'hFFFF_FFFF;
        if (addr_s >= 14'd4) oob_s <= oob_s + 1;
        if (int'(addr_b) > max_addr_b) max_addr_b <= int'(addr_b);
    end

    typedef struct {
        int          cyc;
        logic [13:0] addr;
        logic        busy;
        logic        done;
        int          total;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Start at cycle 0, then compare every cycle against the table.
    task automatic run_table(input bit extra_start);
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            start = extra_start && (tbl[k].cyc == 2);
            chk($sformatf("addr_c%0d", tbl[k].cyc),  addr_s,  tbl[k].addr);
            chk($sformatf("busy_c%0d", tbl[k].cyc),  busy_s,  tbl[k].busy);
            chk($sformatf("done_c%0d", tbl[k].cyc),  done_s,  tbl[k].done);
            chk($sformatf("total_c%0d", tbl[k].cyc), total_s, tbl[k].total);
        end
        start = 1'b0;
    endtask

    task automatic run_to_done(input bit big, input int budget, output int cyc, output bit ok);
        @(negedge clk);
        if (big) start_big = 1'b1; else start = 1'b1;
        cyc = 0;
        ok  = 1'b0;
        while (cyc < budget && !ok) begin
            @(negedge clk);
            start     = 1'b0;
            start_big = 1'b0;
            cyc++;
            ok = big ? done_b : done_s;
        end
    endtask

    initial begin
        int cyc;
        bit ok;

        oob_s      = 0;
        max_addr_b = 0;
        mem[0] = 32'hFFFF_FFFF;
        mem[1] = 32'h0000_0001;
        mem[2] = 32'h8000_0000;
        mem[3] = 32'h0000_0000;

        tbl[0] = '{1, 14'd0, 1'b1, 1'b0, 0};
        tbl[1] = '{2, 14'd1, 1'b1, 1'b0, 0};
`ifdef ROM_SCAN_POPCNT_PIPE_EN
        tbl[2] = '{3, 14'd2, 1'b1, 1'b0, 0};
        tbl[3] = '{4, 14'd3, 1'b1, 1'b0, 32};
        tbl[4] = '{5, 14'd3, 1'b1, 1'b0, 33};
        tbl[5] = '{6, 14'd3, 1'b1, 1'b0, 34};
        tbl[6] = '{7, 14'd3, 1'b0, 1'b1, 34};
`else
        tbl[2] = '{3, 14'd2, 1'b1, 1'b0, 32};
        tbl[3] = '{4, 14'd3, 1'b1, 1'b0, 33};
        tbl[4] = '{5, 14'd3, 1'b1, 1'b0, 34};
        tbl[5] = '{6, 14'd3, 1'b0, 1'b1, 34};
        tbl[6] = '{7, 14'd3, 1'b0, 1'b1, 34};
`endif

        rst       = 1'b1;
        start     = 1'b0;
        start_big = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_addr",  addr_s,  0);
        chk("rst_busy",  busy_s,  0);
        chk("rst_done",  done_s,  0);
        chk("rst_total", total_s, 0);
        rst = 1'b0;

        // Plain sweep from IDLE, then a restart from DONE with a stray start in cycle 2.
        run_table(1'b0);
        run_table(1'b1);

        // Restart with an all-zero ROM: total clears on the start edge.
        for (int i = 0; i < 4; i++) mem[i] = 32'h0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("zero_total_at_start", total_s, 0);
        chk("zero_done_dropped",   done_s,  0);
        chk("zero_busy",           busy_s,  1);
        cyc = 1;
        while (cyc < 50 && !done_s) begin
            @(negedge clk);
            cyc++;
        end
        chk("zero_done_cycle", cyc, 4 + LAT);
        chk("zero_total",      total_s, 0);

        // Reset in cycle 3 of a sweep, then a clean rerun.
        mem[0] = 32'hFFFF_FFFF;
        mem[1] = 32'h0000_0001;
        mem[2] = 32'h8000_0000;
        mem[3] = 32'h0000_0000;
        @(negedge clk);
        start = 1'b1;
        repeat (3) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        chk("midrst_addr",  addr_s,  0);
        chk("midrst_busy",  busy_s,  0);
        chk("midrst_done",  done_s,  0);
        chk("midrst_total", total_s, 0);
        @(negedge clk);
        rst = 1'b0;
        run_to_done(1'b0, 50, cyc, ok);
        chk("rerun_done_seen", ok, 1);
        chk("rerun_done_cycle", cyc, 4 + LAT);
        chk("rerun_total", total_s, 34);
        chk("small_addr_range", oob_s, 0);

        // Full-depth sweep with every flag set.
        run_to_done(1'b1, 13000, cyc, ok);
        chk("big_done_seen", ok, 1);
        chk("big_done_cycle", cyc, 12224 + LAT);
        chk("big_total", total_b, 391168);
        chk("big_max_addr", max_addr_b, 12223);
        chk("big_busy_low", busy_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
